// File: rtl/bg_tile_fetch_sequencer.sv
// Background tile fetch sequencer: walks one scanline tile by tile, issuing NT/AT/pattern reads on a
// VRAM port shared with CPU accesses, and hands each completed tile record downstream.
`timescale 1ns/1ps
module bg_tile_fetch_sequencer #(
    parameter int unsigned TILES_PER_LINE = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_line,
    input  logic [8:0]  line_row,
    input  logic        render_en,
    input  logic [7:0]  ppu_ctrl1,
    output logic [8:0]  map_row,
    output logic [8:0]  map_col,
    input  logic [15:0] map_nt_ptr,
    input  logic [2:0]  map_fine_y,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_pat_lo,
    output logic [7:0]  tile_pat_hi,
    output logic [1:0]  tile_attr,
    output logic        line_busy
);

    localparam logic [5:0] LastIdx = 6'(TILES_PER_LINE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCpu,
        StNt,
        StAt,
        StPlo,
        StPhi,
        StPush
    } state_e;

    state_e      state_q;
    logic [8:0]  row_q;
    logic [5:0]  tile_idx_q;
    logic [7:0]  tile_id_q;
    logic [15:0] nt_ptr_q;
    logic [2:0]  fine_y_q;
    logic [1:0]  attr_q;
    logic [7:0]  pat_lo_q;

    logic [15:0] at_addr;
    logic [15:0] pat_addr;
    logic [15:0] fetch_addr;
    logic [2:0]  attr_shift;
    logic [1:0]  attr_bits;
    logic        aborting;
    logic        cpu_pending;
    logic        unused_ctrl;

    assign map_row = row_q;
    assign map_col = {tile_idx_q, 3'b000};

    assign at_addr    = {nt_ptr_q[15:10], 4'hF, nt_ptr_q[9:7], nt_ptr_q[4:2]};
    assign pat_addr   = {3'b000, ppu_ctrl1[4], tile_id_q, 1'b0, fine_y_q};
    assign attr_shift = {nt_ptr_q[6], nt_ptr_q[1], 1'b0};
    assign attr_bits  = 2'(vram_rdata >> attr_shift);
    assign aborting   = line_busy && !render_en;
    // cpu_req may still be high in the cycle cpu_ack is out; do not serve it twice.
    assign cpu_pending = cpu_req && !cpu_ack;
    assign unused_ctrl = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:0]};

    always_comb begin
        fetch_addr = map_nt_ptr;
        case (state_q)
            StAt:    fetch_addr = at_addr;
            StPlo:   fetch_addr = pat_addr;
            StPhi:   fetch_addr = pat_addr | 16'h0008;
            default: fetch_addr = map_nt_ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            row_q       <= '0;
            tile_idx_q  <= '0;
            tile_id_q   <= '0;
            nt_ptr_q    <= '0;
            fine_y_q    <= '0;
            attr_q      <= '0;
            pat_lo_q    <= '0;
            vram_req    <= 1'b0;
            vram_addr   <= '0;
            vram_we     <= 1'b0;
            vram_wdata  <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            tile_valid  <= 1'b0;
            tile_pat_lo <= '0;
            tile_pat_hi <= '0;
            tile_attr   <= '0;
            line_busy   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cpu_pending) begin
                        state_q <= StCpu;
                    end else if (start_line && render_en) begin
                        row_q      <= line_row;
                        tile_idx_q <= '0;
                        line_busy  <= 1'b1;
                        state_q    <= StNt;
                    end
                end

                StCpu: begin
                    if (!vram_req) begin
                        vram_req   <= 1'b1;
                        vram_addr  <= cpu_addr;
                        vram_we    <= cpu_we;
                        vram_wdata <= cpu_wdata;
                    end else if (vram_ack) begin
                        vram_req <= 1'b0;
                        vram_we  <= 1'b0;
                        cpu_ack  <= 1'b1;
                        if (!vram_we) begin
                            cpu_rdata <= vram_rdata;
                        end
                        if (line_busy && render_en) begin
                            state_q <= StNt;
                        end else begin
                            line_busy <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                end

                StNt, StAt, StPlo, StPhi: begin
                    if (!vram_req) begin
                        // Abort before the request goes out; nothing is in flight yet.
                        if (aborting) begin
                            line_busy <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            vram_req  <= 1'b1;
                            vram_we   <= 1'b0;
                            vram_addr <= fetch_addr;
                        end
                    end else if (vram_ack) begin
                        vram_req <= 1'b0;
                        if (aborting) begin
                            line_busy <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            case (state_q)
                                StNt: begin
                                    tile_id_q <= vram_rdata;
                                    nt_ptr_q  <= map_nt_ptr;
                                    fine_y_q  <= map_fine_y;
                                    state_q   <= StAt;
                                end
                                StAt: begin
                                    attr_q  <= attr_bits;
                                    state_q <= StPlo;
                                end
                                StPlo: begin
                                    pat_lo_q <= vram_rdata;
                                    state_q  <= StPhi;
                                end
                                default: begin
                                    tile_pat_lo <= pat_lo_q;
                                    tile_pat_hi <= vram_rdata;
                                    tile_attr   <= attr_q;
                                    tile_valid  <= 1'b1;
                                    state_q     <= StPush;
                                end
                            endcase
                        end
                    end
                end

                StPush: begin
                    if (aborting) begin
                        tile_valid <= 1'b0;
                        line_busy  <= 1'b0;
                        state_q    <= StIdle;
                    end else if (tile_ready) begin
                        tile_valid <= 1'b0;
                        if (tile_idx_q == LastIdx) begin
                            line_busy <= 1'b0;
                            state_q   <= cpu_pending ? StCpu : StIdle;
                        end else begin
                            tile_idx_q <= 6'(tile_idx_q + 6'd1);
                            state_q    <= cpu_pending ? StCpu : StNt;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_tile_fetch_sequencer.sv
// Directed bench for bg_tile_fetch_sequencer: VRAM responder with programmable latency, a simple
// scroll-0 mapper, and a posedge monitor logging every completed access and accepted tile.
`timescale 1ns/1ps
module tb_bg_tile_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_line;
    logic [8:0]  line_row;
    logic        render_en;
    logic [7:0]  ppu_ctrl1;
    logic [8:0]  map_row;
    logic [8:0]  map_col;
    logic [15:0] map_nt_ptr;
    logic [2:0]  map_fine_y;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic [1:0]  tile_attr;
    logic        line_busy;

    int total = 0;
    int bad   = 0;
    int unsigned lat = 1;

    always #5 clk = ~clk;

    bg_tile_fetch_sequencer #(.TILES_PER_LINE(33)) dut (
        .clk(clk), .rst_n(rst_n), .start_line(start_line), .line_row(line_row),
        .render_en(render_en), .ppu_ctrl1(ppu_ctrl1), .map_row(map_row), .map_col(map_col),
        .map_nt_ptr(map_nt_ptr), .map_fine_y(map_fine_y), .vram_req(vram_req),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_pat_lo(tile_pat_lo),
        .tile_pat_hi(tile_pat_hi), .tile_attr(tile_attr), .line_busy(line_busy)
    );

    // Scroll-0 mapper; col 256 spills into the right-hand nametable.
    assign map_nt_ptr = 16'h2000 | (map_col[8] ? 16'h0400 : 16'h0000)
                      | (map_row[8] ? 16'h0800 : 16'h0000) | {6'd0, map_row[7:3], map_col[7:3]};
    assign map_fine_y = map_row[2:0];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        case (a)
            16'h2000: init_val = 8'h05;
            16'h23C0: init_val = 8'hE4;
            16'h23C9: init_val = 8'hE4;
            16'h1050: init_val = 8'hAA;
            16'h1058: init_val = 8'h55;
            default:  init_val = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] mem     [0:65535];
    bit         written [0:65535];
    int unsigned rsp_cnt = 0;
    bit          ack_given = 1'b0;

    always @(negedge clk) begin
        if (vram_req && !ack_given) begin
            rsp_cnt = rsp_cnt + 1;
            if (rsp_cnt >= lat) begin
                vram_ack   = 1'b1;
                vram_rdata = written[vram_addr] ? mem[vram_addr] : init_val(vram_addr);
                if (vram_we) begin
                    mem[vram_addr]     = vram_wdata;
                    written[vram_addr] = 1'b1;
                end
                ack_given = 1'b1;
            end else begin
                vram_ack = 1'b0;
            end
        end else begin
            vram_ack = 1'b0;
            if (!vram_req) begin
                rsp_cnt   = 0;
                ack_given = 1'b0;
            end
        end
    end

    logic [15:0] log_addr  [0:4095];
    logic        log_we    [0:4095];
    logic [7:0]  log_wd    [0:4095];
    int          log_tiles [0:4095];
    logic [7:0]  t_lo      [0:1023];
    logic [7:0]  t_hi      [0:1023];
    logic [1:0]  t_attr    [0:1023];
    int n_acc = 0;
    int n_tile = 0;
    int n_cpu_ack = 0;
    int viol = 0;
    logic        last_req = 1'b0;
    logic        last_ack = 1'b0;
    logic        last_rst = 1'b0;
    logic [15:0] last_addr = 16'h0;

    always @(posedge clk) begin
        // Once raised, a request must stay up with a stable address until acked.
        if (rst_n && last_rst && last_req && !last_ack
            && (!vram_req || vram_addr != last_addr)) begin
            viol = viol + 1;
        end
        if (vram_req && vram_ack && n_acc < 4096) begin
            log_addr[n_acc]  = vram_addr;
            log_we[n_acc]    = vram_we;
            log_wd[n_acc]    = vram_wdata;
            log_tiles[n_acc] = n_tile;
            n_acc = n_acc + 1;
        end
        if (tile_valid && tile_ready && n_tile < 1024) begin
            t_lo[n_tile]   = tile_pat_lo;
            t_hi[n_tile]   = tile_pat_hi;
            t_attr[n_tile] = tile_attr;
            n_tile = n_tile + 1;
        end
        if (cpu_ack) n_cpu_ack = n_cpu_ack + 1;
        last_req  = vram_req;
        last_ack  = vram_ack;
        last_rst  = rst_n;
        last_addr = vram_addr;
    end

    task automatic pulse_start(input logic [8:0] row);
        @(negedge clk);
        start_line = 1'b1;
        line_row   = row;
        @(negedge clk);
        start_line = 1'b0;
    endtask

    task automatic wait_line_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!line_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({vram_req, vram_we, cpu_ack, tile_valid, line_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {vram_req, vram_we, cpu_ack, tile_valid, line_busy});
        end
        total++;
        if ({vram_addr, vram_wdata, cpu_rdata, tile_pat_lo, tile_pat_hi, tile_attr, map_row,
             map_col} !== '0) begin
            bad++;
            $display("FAIL reset_data got addr=%h pl=%h ph=%h at=%h row=%h col=%h exp=all 0",
                     vram_addr, tile_pat_lo, tile_pat_hi, tile_attr, map_row, map_col);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_line0();
        int ba = n_acc;
        int bt = n_tile;
        bit ok;
        pulse_start(9'd0);
        repeat (20) @(negedge clk);
        pulse_start(9'd100); // must be ignored while the line is busy
        wait_line_done(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL line0_timeout got=%0d exp=1", ok); end
        total++;
        if (n_tile - bt !== 33) begin
            bad++; $display("FAIL line0_tiles got=%0d exp=33", n_tile - bt);
        end
        total++;
        if (n_acc - ba !== 132) begin
            bad++; $display("FAIL line0_accesses got=%0d exp=132", n_acc - ba);
        end
        total++;
        if ({log_addr[ba], log_addr[ba+1], log_addr[ba+2], log_addr[ba+3]}
            !== {16'h2000, 16'h23C0, 16'h1050, 16'h1058}) begin
            bad++;
            $display("FAIL line0_addr_order got=%h %h %h %h exp=2000 23c0 1050 1058",
                     log_addr[ba], log_addr[ba+1], log_addr[ba+2], log_addr[ba+3]);
        end
        total++;
        if ({t_lo[bt], t_hi[bt], t_attr[bt]} !== {8'hAA, 8'h55, 2'd0}) begin
            bad++;
            $display("FAIL tile0_record got=%h/%h/%0d exp=aa/55/0", t_lo[bt], t_hi[bt], t_attr[bt]);
        end
        total++;
        if (log_addr[ba+10] !== 16'h1580) begin
            bad++; $display("FAIL tile2_plo_addr got=%h exp=1580", log_addr[ba+10]);
        end
        total++;
        if (t_attr[bt+2] !== 2'd1) begin
            bad++; $display("FAIL tile2_attr got=%0d exp=1", t_attr[bt+2]);
        end
        total++;
        if (log_addr[ba+128] !== 16'h2400) begin
            bad++; $display("FAIL tile32_nt_addr got=%h exp=2400", log_addr[ba+128]);
        end
    endtask

    task automatic test_attr_quadrant();
        int ba = n_acc;
        int bt = n_tile;
        bit ok;
        pulse_start(9'd19);
        wait_line_done(ok);
        total++;
        if ({t_attr[bt], t_attr[bt+2]} !== {2'd2, 2'd3}) begin
            bad++;
            $display("FAIL attr_row19 got=%0d,%0d exp=2,3", t_attr[bt], t_attr[bt+2]);
        end
        total++;
        if ({log_addr[ba+8], log_addr[ba+10], log_addr[ba+11]}
            !== {16'h2042, 16'h1183, 16'h118B}) begin
            bad++;
            $display("FAIL fine_y_addrs got=%h %h %h exp=2042 1183 118b",
                     log_addr[ba+8], log_addr[ba+10], log_addr[ba+11]);
        end
        ba = n_acc;
        bt = n_tile;
        pulse_start(9'd48);
        wait_line_done(ok);
        total++;
        if ({log_addr[ba+25], t_attr[bt+6]} !== {16'h23C9, 2'd3}) begin
            bad++;
            $display("FAIL attr_20c6 got=%h/%0d exp=23c9/3", log_addr[ba+25], t_attr[bt+6]);
        end
    endtask

    task automatic test_cpu_read_idle();
        int ba = n_acc;
        int bc = n_cpu_ack;
        bit ok = 1'b0;
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_addr   = 16'h23C0;
        cpu_we     = 1'b0;
        start_line = 1'b1;
        line_row   = 9'd0;
        @(negedge clk);
        start_line = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cpu_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if ({ok, cpu_rdata} !== {1'b1, 8'hE4}) begin
            bad++; $display("FAIL cpu_read got=%0d/%h exp=1/e4", ok, cpu_rdata);
        end
        cpu_req = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if ({line_busy, 32'(n_acc - ba), 32'(n_cpu_ack - bc)} !== {1'b0, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL start_lost_to_cpu got=busy%0d acc%0d ack%0d exp=busy0 acc1 ack1",
                     line_busy, n_acc - ba, n_cpu_ack - bc);
        end
    endtask

    task automatic test_cpu_during_line();
        int ba = n_acc;
        int bt = n_tile;
        int bc = n_cpu_ack;
        bit ok_nt = 1'b0;
        bit ok_ack = 1'b0;
        bit ok;
        pulse_start(9'd8);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_acc - ba == 16 && vram_req) begin
                ok_nt = 1'b1;
                break;
            end
        end
        cpu_req   = 1'b1;
        cpu_addr  = 16'h2105;
        cpu_we    = 1'b1;
        cpu_wdata = 8'h3C;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ok_ack = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        wait_line_done(ok);
        total++;
        if ({ok_nt, ok_ack, ok} !== 3'b111) begin
            bad++; $display("FAIL cpu_line_timeouts got=%b exp=111", {ok_nt, ok_ack, ok});
        end
        total++;
        if ({log_addr[ba+20], log_we[ba+20], log_wd[ba+20]} !== {16'h2105, 1'b1, 8'h3C}) begin
            bad++;
            $display("FAIL cpu_write_slot got=%h/%0d/%h exp=2105/1/3c",
                     log_addr[ba+20], log_we[ba+20], log_wd[ba+20]);
        end
        total++;
        if (log_tiles[ba+20] - bt !== 5) begin
            bad++; $display("FAIL cpu_after_tile4 got=%0d exp=5", log_tiles[ba+20] - bt);
        end
        total++;
        if ({log_addr[ba+16], log_addr[ba+21], log_we[ba+21]} !== {16'h2024, 16'h2025, 1'b0}) begin
            bad++;
            $display("FAIL cpu_neighbours got=%h %h/%0d exp=2024 2025/0",
                     log_addr[ba+16], log_addr[ba+21], log_we[ba+21]);
        end
        total++;
        if ({32'(n_tile - bt), 32'(n_acc - ba), 32'(n_cpu_ack - bc)}
            !== {32'd33, 32'd133, 32'd1}) begin
            bad++;
            $display("FAIL cpu_line_counts got=tiles%0d acc%0d ack%0d exp=tiles33 acc133 ack1",
                     n_tile - bt, n_acc - ba, n_cpu_ack - bc);
        end
        total++;
        if (log_addr[ba+129] !== 16'h2420) begin
            bad++; $display("FAIL cpu_line_last_nt got=%h exp=2420", log_addr[ba+129]);
        end
    endtask

    task automatic test_backpressure();
        int bt = n_tile;
        int acc0;
        bit ok_v = 1'b0;
        bit unstable = 1'b0;
        bit ok;
        logic [17:0] rec;
        tile_ready = 1'b0;
        pulse_start(9'd0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tile_valid) begin
                ok_v = 1'b1;
                break;
            end
        end
        rec  = {tile_pat_lo, tile_pat_hi, tile_attr};
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tile_valid !== 1'b1 || vram_req !== 1'b0
                || {tile_pat_lo, tile_pat_hi, tile_attr} !== rec) unstable = 1'b1;
        end
        total++;
        if ({ok_v, rec} !== {1'b1, 8'hAA, 8'h55, 2'd0}) begin
            bad++; $display("FAIL stall_record got=%0d/%h exp=1/%h", ok_v, rec, {8'hAA, 8'h55, 2'd0});
        end
        total++;
        if ({unstable, 32'(n_acc - acc0)} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL stall_hold got=unstable%0d acc%0d exp=unstable0 acc0",
                     unstable, n_acc - acc0);
        end
        tile_ready = 1'b1;
        wait_line_done(ok);
        total++;
        if (n_tile - bt !== 33) begin
            bad++; $display("FAIL stall_line_tiles got=%0d exp=33", n_tile - bt);
        end
    endtask

    task automatic test_abort();
        int ba = n_acc;
        int bt = n_tile;
        int bv = viol;
        bit ok_at = 1'b0;
        bit saw_valid = 1'b0;
        bit ok;
        lat = 3;
        pulse_start(9'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc - ba == 1 && vram_req) begin
                ok_at = 1'b1;
                break;
            end
        end
        render_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tile_valid) saw_valid = 1'b1;
        end
        total++;
        if ({ok_at, saw_valid, 32'(n_acc - ba), 32'(n_tile - bt)}
            !== {1'b1, 1'b0, 32'd2, 32'd0}) begin
            bad++;
            $display("FAIL abort_at got=at%0d valid%0d acc%0d tiles%0d exp=at1 valid0 acc2 tiles0",
                     ok_at, saw_valid, n_acc - ba, n_tile - bt);
        end
        total++;
        if ({line_busy, vram_req, 32'(viol - bv)} !== {1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL abort_idle got=busy%0d req%0d viol%0d exp=busy0 req0 viol0",
                     line_busy, vram_req, viol - bv);
        end
        lat = 1;
        render_en = 1'b1;
        pulse_start(9'd0);
        total++;
        if (line_busy !== 1'b1) begin
            bad++; $display("FAIL abort_restart got=%0d exp=1", line_busy);
        end
        wait_line_done(ok);
    endtask

    task automatic test_reset_mid_phi();
        int ba = n_acc;
        bit ok_phi = 1'b0;
        bit ok;
        lat = 6;
        pulse_start(9'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_acc - ba == 3 && vram_req) begin
                ok_phi = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({ok_phi, vram_req, tile_valid, line_busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_mid_phi got=%b exp=1000", {ok_phi, vram_req, tile_valid, line_busy});
        end
        rst_n = 1'b1;
        lat   = 1;
        ba    = n_acc;
        pulse_start(9'd0);
        wait_line_done(ok);
        total++;
        if ({ok, log_addr[ba]} !== {1'b1, 16'h2000}) begin
            bad++; $display("FAIL reset_then_line got=%0d/%h exp=1/2000", ok, log_addr[ba]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start_line = 1'b0;
        line_row   = 9'd0;
        render_en  = 1'b1;
        ppu_ctrl1  = 8'h10;
        cpu_req    = 1'b0;
        cpu_addr   = 16'h0;
        cpu_we     = 1'b0;
        cpu_wdata  = 8'h0;
        tile_ready = 1'b1;
        test_reset();
        test_line0();
        test_attr_quadrant();
        test_cpu_read_idle();
        test_cpu_during_line();
        test_backpressure();
        test_abort();
        test_reset_mid_phi();
        total++;
        if (viol !== 0) begin
            bad++; $display("FAIL req_protocol got=%0d exp=0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
